alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: XLEN, 64, datapath width of operands, pc and register data.
REQ-002 Parameter: DEPTH, 2, entries in output buffer; only 2 is supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  upstream offers one instruction.
REQ-006 in_ready  output  1  block can accept; transfer when in_valid && in_ready.
REQ-007 in_inst  input  32  instruction word.
REQ-008 in_pc  input  XLEN  instruction address.
REQ-009 in_rs1_data / in_rs2_data  input  XLEN each  source register values.
REQ-010 out_valid  output  1  entry presented to ALU stage.
REQ-011 out_ready  input  1  downstream consumes; transfer when out_valid && out_ready.
REQ-012 out_alu_funct  output  4  ALU function: [3] ADD/SUB and SRL/SRA select, [2:0] funct3 group.
REQ-013 out_operand_a / out_operand_b  output  XLEN each  ALU operands.
REQ-014 out_rd  output  5  destination register, inst[11:7].
REQ-015 out_word  output  1  32-bit (W) operation.
REQ-016 out_illegal  output  1  instruction not decodable by this block.

Function
REQ-017 Decode is combinational on the input; the result is written into a 2-entry FIFO; latency accept-to-out_valid = 1 cycle, no combinational path input-to-output.
REQ-018 in_ready SHALL be registered, 1 when FIFO count < 2; no dependence on out_ready.
REQ-019 Push and pop in the same cycle with count 1 keeps count 1, output advances to new entry only if the old one was popped.
REQ-020 While out_valid && !out_ready, all out_* payload SHALL be held stable.
REQ-021 Entries SHALL be delivered strictly in acceptance order; none dropped or duplicated.
REQ-022 OP (0110011): a=rs1, b=rs2, funct[2:0]=funct3, funct[3]=inst[30]; legal only for funct7=0000000, or 0100000 with funct3 000/101.
REQ-023 OP-IMM (0010011): a=rs1, b=sign-extended inst[31:20]; funct[3]=0 except funct3=101 where funct[3]=inst[30]; funct3 001 legal only with inst[31:26]=000000; 101 legal with 000000 or 010000; b=zero-extended shamt inst[25:20] for shifts.
REQ-024 LUI: a=0, b=sign-extended {inst[31:12],12'b0}, funct=ADD.
REQ-025 AUIPC: a=pc, b=sign-extended {inst[31:12],12'b0}, funct=ADD.
REQ-026 Any other opcode or illegal field: entry still enqueued with out_illegal=1, funct=0000, operands 0, out_word=0.
REQ-027 out_word=0 for all non-W encodings.

Reset
REQ-028 On rst_n low: FIFO emptied, out_valid=0, in_ready=0 while asserted, all payload outputs 0.
REQ-029 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-030 Reset mid-transfer discards all buffered entries; none reappear after reset.

Configuration
REQ-031 Macro ALU_ISSUE_WORD_OPS_EN defined: OP-32 (0111011) and OP-IMM-32 (0011011) decoded as REQ-022/023 with out_word=1, legal funct3 limited to 000/001/101, shamt 5 bits (inst[25]=1 illegal).
REQ-032 Macro undefined: those opcodes SHALL produce out_illegal=1 and out_word tied 0.

Structure
REQ-033 Shared package holds opcode constants, ALU funct3 codes (ADD_SUB=000, SLL=001, SLT=010, SLTU=011, XOR=100, SHIFTR=101, OR=110, AND=111) and the decoded-entry struct typedef.
REQ-034 One sub-module alu_issue_decode (pure combinational decoder); FIFO kept inline.

Verification
REQ-035 Reset then OP inst 0x40208033 (sub x0,x1,x2), rs1=10, rs2=3 -> next cycle out_valid=1, funct=1000, a=10, b=3, illegal=0.
REQ-036 OP-IMM 0xFFF00093 (addi x1,x0,-1) -> b=0xFFFFFFFFFFFFFFFF, funct=0000, rd=1.
REQ-037 OP-IMM srai inst 0x4030D093 -> funct=1101, b=3; inst 0x4030 9093 (slli with bit30) -> illegal=1.
REQ-038 AUIPC 0x80000017 with pc=0x1000 -> a=0x1000, b=0xFFFFFFFF80000000, funct=0000.
REQ-039 Hold out_ready=0, push 3 back-to-back -> in_ready=0 after 2 accepted, payload stable; release -> 3 entries delivered in order.
REQ-040 Assert rst_n low with 2 entries buffered -> out_valid=0 immediately; after release no stale entries; OP-32 0x0000003B gives out_word=1 with macro, out_illegal=1 without.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue block: opcodes, ALU funct3 codes and
// the decoded control fields carried through the output buffer.
package alu_issue_pkg;

   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SHIFTR  = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Operands are XLEN-wide and live beside this struct in the buffer.
   typedef struct packed {
      logic [3:0] funct;
      logic [4:0] rd;
      logic       word;
      logic       illegal;
   } dec_ctrl_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational instruction decoder for the ALU issue block.
// W-form opcodes are decoded only when ALU_ISSUE_WORD_OPS_EN is defined.
module alu_issue_decode
   import alu_issue_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic [31:0]      inst,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  rs1_data,
   input  logic [XLEN-1:0]  rs2_data,
   output dec_ctrl_t        ctrl,
   output logic [XLEN-1:0]  operand_a,
   output logic [XLEN-1:0]  operand_b
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] shamt6;
   logic            legal;
   logic [3:0]      funct;
   logic            word;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign funct7 = inst[31:25];
   assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};
   assign imm_u  = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
   assign shamt6 = {{(XLEN-6){1'b0}}, inst[25:20]};

`ifdef ALU_ISSUE_WORD_OPS_EN
   logic [XLEN-1:0] shamt5;
   assign shamt5 = {{(XLEN-5){1'b0}}, inst[24:20]};
`endif

   // Raw field decode and legality per opcode.
   always_comb begin
      legal = 1'b0;
      funct = 4'b0000;
      word  = 1'b0;
      a     = '0;
      b     = '0;
      case (opcode)
         OPC_OP: begin
            a     = rs1_data;
            b     = rs2_data;
            funct = {inst[30], funct3};
            legal = (funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SHIFTR)));
         end
         OPC_OP_IMM: begin
            a     = rs1_data;
            b     = imm_i;
            funct = {1'b0, funct3};
            legal = 1'b1;
            if (funct3 == F3_SLL) begin
               b     = shamt6;
               legal = (inst[31:26] == 6'b000000);
            end else if (funct3 == F3_SHIFTR) begin
               b     = shamt6;
               funct = {inst[30], funct3};
               legal = (inst[31:26] == 6'b000000) || (inst[31:26] == 6'b010000);
            end
         end
         OPC_LUI: begin
            b     = imm_u;
            legal = 1'b1;
         end
         OPC_AUIPC: begin
            a     = pc;
            b     = imm_u;
            legal = 1'b1;
         end
`ifdef ALU_ISSUE_WORD_OPS_EN
         OPC_OP_32: begin
            a     = rs1_data;
            b     = rs2_data;
            funct = {inst[30], funct3};
            word  = 1'b1;
            legal = ((funct3 == F3_ADD_SUB) || (funct3 == F3_SLL) || (funct3 == F3_SHIFTR)) &&
                    ((funct7 == F7_BASE) || ((funct7 == F7_ALT) && (funct3 != F3_SLL)));
         end
         OPC_OP_IMM_32: begin
            a     = rs1_data;
            b     = imm_i;
            funct = {1'b0, funct3};
            word  = 1'b1;
            if (funct3 == F3_ADD_SUB) begin
               legal = 1'b1;
            end else if (funct3 == F3_SLL) begin
               b     = shamt5;
               legal = (funct7 == F7_BASE);
            end else if (funct3 == F3_SHIFTR) begin
               b     = shamt5;
               funct = {inst[30], funct3};
               legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            end else begin
               legal = 1'b0;
            end
         end
`endif
         default: legal = 1'b0;
      endcase
   end

   // Illegal encodings collapse to a zeroed entry with only the flag set.
   always_comb begin
      ctrl.rd      = inst[11:7];
      ctrl.illegal = !legal;
      ctrl.funct   = legal ? funct : 4'b0000;
      ctrl.word    = legal ? word : 1'b0;
      operand_a    = legal ? a : '0;
      operand_b    = legal ? b : '0;
   end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes one instruction per transfer into a 2-entry
// output FIFO. Optional W-form decode is enabled by ALU_ISSUE_WORD_OPS_EN.
module alu_issue
   import alu_issue_pkg::*;
#(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_rs1_data,
   input  logic [XLEN-1:0]  in_rs2_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_alu_funct,
   output logic [XLEN-1:0]  out_operand_a,
   output logic [XLEN-1:0]  out_operand_b,
   output logic [4:0]       out_rd,
   output logic             out_word,
   output logic             out_illegal
);

   localparam logic [1:0] FULL = 2'(DEPTH);

   dec_ctrl_t       dec_ctrl;
   logic [XLEN-1:0] dec_a;
   logic [XLEN-1:0] dec_b;

   dec_ctrl_t       ctrl_mem [2];
   logic [XLEN-1:0] a_mem    [2];
   logic [XLEN-1:0] b_mem    [2];
   logic            wr_ptr;
   logic            rd_ptr;
   logic [1:0]      count_q;
   logic [1:0]      count_d;
   logic            in_ready_q;
   logic            push;
   logic            pop;

   alu_issue_decode #(
      .XLEN (XLEN)
   ) u_decode (
      .inst      (in_inst),
      .pc        (in_pc),
      .rs1_data  (in_rs1_data),
      .rs2_data  (in_rs2_data),
      .ctrl      (dec_ctrl),
      .operand_a (dec_a),
      .operand_b (dec_b)
   );

   assign push = in_valid && in_ready_q;
   assign pop  = (count_q != 2'd0) && out_ready;

   // Occupancy after this cycle's push/pop.
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // FIFO storage, pointers and registered ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            ctrl_mem[i] <= '0;
            a_mem[i]    <= '0;
            b_mem[i]    <= '0;
         end
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count_q    <= 2'd0;
         in_ready_q <= 1'b0;
      end else begin
         if (push) begin
            ctrl_mem[wr_ptr] <= dec_ctrl;
            a_mem[wr_ptr]    <= dec_a;
            b_mem[wr_ptr]    <= dec_b;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count_q    <= count_d;
         // Ready depends only on occupancy, never on out_ready.
         in_ready_q <= (count_d != FULL);
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = (count_q != 2'd0);
   assign out_alu_funct = ctrl_mem[rd_ptr].funct;
   assign out_rd        = ctrl_mem[rd_ptr].rd;
   assign out_word      = ctrl_mem[rd_ptr].word;
   assign out_illegal   = ctrl_mem[rd_ptr].illegal;
   assign out_operand_a = a_mem[rd_ptr];
   assign out_operand_b = b_mem[rd_ptr];

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue.
module tb_alu_issue;

   localparam int unsigned XLEN = 64;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_rs1_data;
   logic [XLEN-1:0] in_rs2_data;
   logic            out_valid;
   logic            out_ready;
   logic [3:0]      out_alu_funct;
   logic [XLEN-1:0] out_operand_a;
   logic [XLEN-1:0] out_operand_b;
   logic [4:0]      out_rd;
   logic            out_word;
   logic            out_illegal;

   int vectors;
   int miscompares;

   alu_issue #(
      .XLEN  (XLEN),
      .DEPTH (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_inst       (in_inst),
      .in_pc         (in_pc),
      .in_rs1_data   (in_rs1_data),
      .in_rs2_data   (in_rs2_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_alu_funct (out_alu_funct),
      .out_operand_a (out_operand_a),
      .out_operand_b (out_operand_b),
      .out_rd        (out_rd),
      .out_word      (out_word),
      .out_illegal   (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Offer one instruction for a single cycle, starting from a negedge.
   task automatic drive(input logic [31:0] inst, input logic [63:0] pc,
                        input logic [63:0] rs1, input logic [63:0] rs2);
      in_inst     = inst;
      in_pc       = pc;
      in_rs1_data = rs1;
      in_rs2_data = rs2;
      in_valid    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b1;
      in_valid    = 1'b0;
      in_inst     = '0;
      in_pc       = '0;
      in_rs1_data = '0;
      in_rs2_data = '0;
      out_ready   = 1'b0;

      // Reset state
      #1 rst_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_operand_b", out_operand_b, 0);
      check("rst_funct", out_alu_funct, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready_held", in_ready, 0);
      rst_n = 1'b1;
      #1 check("in_ready_before_edge", in_ready, 0);
      @(negedge clk);
      check("in_ready_after_edge", in_ready, 1);
      check("idle_out_valid", out_valid, 0);

      // sub x0,x1,x2
      drive(32'h4020_8033, 64'h0, 64'd10, 64'd3);
      check("sub_valid", out_valid, 1);
      check("sub_funct", out_alu_funct, 4'b1000);
      check("sub_a", out_operand_a, 64'd10);
      check("sub_b", out_operand_b, 64'd3);
      check("sub_illegal", out_illegal, 0);
      check("sub_word", out_word, 0);
      pop_one();
      check("sub_drained", out_valid, 0);

      // addi x1,x0,-1
      drive(32'hFFF0_0093, 64'h0, 64'd0, 64'd77);
      check("addi_b", out_operand_b, 64'hFFFF_FFFF_FFFF_FFFF);
      check("addi_funct", out_alu_funct, 4'b0000);
      check("addi_rd", out_rd, 5'd1);
      check("addi_illegal", out_illegal, 0);
      pop_one();

      // srai x1,x1,3
      drive(32'h4030_D093, 64'h0, 64'h8000_0000_0000_0000, 64'd0);
      check("srai_funct", out_alu_funct, 4'b1101);
      check("srai_b", out_operand_b, 64'd3);
      check("srai_a", out_operand_a, 64'h8000_0000_0000_0000);
      pop_one();

      // slli with bit30 set is illegal
      drive(32'h4030_9093, 64'h0, 64'd5, 64'd6);
      check("slli30_illegal", out_illegal, 1);
      check("slli30_funct", out_alu_funct, 0);
      check("slli30_a", out_operand_a, 0);
      check("slli30_b", out_operand_b, 0);
      pop_one();

      // auipc x0,0x80000
      drive(32'h8000_0017, 64'h1000, 64'd1, 64'd2);
      check("auipc_a", out_operand_a, 64'h1000);
      check("auipc_b", out_operand_b, 64'hFFFF_FFFF_8000_0000);
      check("auipc_funct", out_alu_funct, 4'b0000);
      pop_one();

      // lui x0,0x12345
      drive(32'h1234_5037, 64'h2000, 64'd1, 64'd2);
      check("lui_a", out_operand_a, 0);
      check("lui_b", out_operand_b, 64'h0000_0000_1234_5000);
      pop_one();

      // Unknown opcode
      drive(32'h0000_007F, 64'h0, 64'd1, 64'd2);
      check("badop_illegal", out_illegal, 1);
      check("badop_a", out_operand_a, 0);
      pop_one();

      // Back-pressure: A, B accepted, C stalls.
      in_inst = 32'h0050_0093; in_valid = 1'b1;   // addi x1,x0,5
      @(posedge clk); @(negedge clk);
      in_inst = 32'h0060_0113;                    // addi x2,x0,6
      @(posedge clk); @(negedge clk);
      check("full_in_ready", in_ready, 0);
      in_inst = 32'h0070_0193;                    // addi x3,x0,7
      @(posedge clk); @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_rd", out_rd, 5'd1);
      check("stall_b", out_operand_b, 64'd5);
      @(posedge clk); @(negedge clk);
      check("stall_hold_b", out_operand_b, 64'd5);
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      check("drain_b_rd", out_rd, 5'd2);
      check("drain_b_b", out_operand_b, 64'd6);
      check("drain_in_ready", in_ready, 1);
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      check("drain_c_valid", out_valid, 1);
      check("drain_c_rd", out_rd, 5'd3);
      check("drain_c_b", out_operand_b, 64'd7);
      @(posedge clk); @(negedge clk);
      out_ready = 1'b0;
      check("drain_empty", out_valid, 0);

      // Reset with two entries buffered
      drive(32'h0050_0093, 64'h0, 64'd0, 64'd0);
      drive(32'h0060_0113, 64'h0, 64'd0, 64'd0);
      check("prerst_full", in_ready, 0);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_b", out_operand_b, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("postrst_valid", out_valid, 0);
      check("postrst_in_ready", in_ready, 1);

      // addw x0,x0,x0
      drive(32'h0000_003B, 64'h0, 64'd9, 64'd4);
      check("addw_valid", out_valid, 1);
`ifdef ALU_ISSUE_WORD_OPS_EN
      check("addw_word", out_word, 1);
      check("addw_illegal", out_illegal, 0);
      check("addw_a", out_operand_a, 64'd9);
`else
      check("addw_word", out_word, 0);
      check("addw_illegal", out_illegal, 1);
      check("addw_a", out_operand_a, 0);
`endif
      pop_one();
      check("final_empty", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
